// File: rtl/mealy_pkg.sv
// Shared definitions for the round-robin shared Mealy run-of-ones detector.
package mealy_pkg;

  // Run-counter values of the classic "11" detector: no trailing 1 / one trailing 1.
  localparam int unsigned S0 = 0;
  localparam int unsigned S1 = 1;

  // Width of each optional per-channel hit counter.
  localparam int unsigned HIT_W = 16;

  // Saturating increment: stops at max instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned cnt, input int unsigned max);
    return (cnt >= max) ? max : cnt + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set bit of req at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  // Scan N positions starting at ptr; the first requester found wins.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand     = (32'(ptr) + off) % N;
      cand_idx = IW'(cand);
      if (!any && req[cand_idx]) begin
        any           = 1'b1;
        idx           = cand_idx;
        gnt[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mealy_rr_sched.sv
// One Mealy run-of-ones detector time-shared among NUM_CH serial channels by a
// round-robin arbiter. Optional per-channel hit statistics: MEALY_SCHED_STATS_EN.
module mealy_rr_sched
  import mealy_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 4,
  parameter  int unsigned RUN_LEN = 2,
  localparam int unsigned CH_W    = $clog2(NUM_CH),
  localparam int unsigned CNT_W   = $clog2(RUN_LEN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] w,
  input  logic [NUM_CH-1:0] ch_clr,
  output logic [NUM_CH-1:0] gnt,
  output logic              z_valid,
  output logic [CH_W-1:0]   z_ch,
  output logic              z
`ifdef MEALY_SCHED_STATS_EN
  ,
  output logic [NUM_CH*HIT_W-1:0] hit_cnt
`endif
);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CH_W-1:0]   ptr_q;

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] arb_gnt;
  logic [CH_W-1:0]   win;
  logic              any;
  logic              win_w;
  logic              win_z;
  logic [CNT_W-1:0]  win_cnt_d;
  logic [CH_W-1:0]   ptr_d;

  // A clear in the same cycle always beats the request.
  assign eligible = req & ~ch_clr;

  rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .req (eligible),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (win),
    .any (any)
  );

  // Evaluate the shared detector for the winning channel's stored state.
  always_comb begin
    win_w     = w[win];
    win_z     = win_w && (cnt_q[win] == CNT_W'(RUN_LEN - 1));
    win_cnt_d = win_w ? CNT_W'(sat_inc(32'(cnt_q[win]), RUN_LEN - 1)) : CNT_W'(S0);
    ptr_d     = (win == CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
  end

  // Per-channel detector state, rr pointer and registered result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= CNT_W'(S0);
      ptr_q   <= '0;
      gnt     <= '0;
      z_valid <= 1'b0;
      z_ch    <= '0;
      z       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_clr[i]) cnt_q[i] <= CNT_W'(S0);
      end
      if (any) begin
        cnt_q[win] <= win_cnt_d;
        ptr_q      <= ptr_d;
        gnt        <= arb_gnt;
        z_valid    <= 1'b1;
        z_ch       <= win;
        z          <= win_z;
      end else begin
        gnt     <= '0;
        z_valid <= 1'b0;
        z       <= 1'b0;
      end
    end
  end

`ifdef MEALY_SCHED_STATS_EN
  logic [HIT_W-1:0] hit_q [NUM_CH];

  // Count detections per channel; only reset clears these, not ch_clr.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) hit_q[i] <= '0;
    end else if (any && win_z) begin
      hit_q[win] <= HIT_W'(sat_inc(32'(hit_q[win]), 32'hFFFF));
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) hit_cnt[HIT_W*i +: HIT_W] = hit_q[i];
  end
`endif

endmodule

// File: tb/tb_mealy_rr_sched.sv
// Directed self-checking bench for mealy_rr_sched (NUM_CH=4; RUN_LEN=2 and RUN_LEN=3).
module tb_mealy_rr_sched;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0, w = '0, ch_clr = '0;
  logic [3:0] gnt;
  logic       z_valid, z;
  logic [1:0] z_ch;

  logic [3:0] req3 = '0, w3 = '0, clr3 = '0;
  logic [3:0] gnt3;
  logic       z_valid3, z3;
  logic [1:0] z_ch3;
`ifdef MEALY_SCHED_STATS_EN
  logic [63:0] hit_cnt, hit_cnt3;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  mealy_rr_sched #(.NUM_CH(4), .RUN_LEN(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .w       (w),
    .ch_clr  (ch_clr),
    .gnt     (gnt),
    .z_valid (z_valid),
    .z_ch    (z_ch),
    .z       (z)
`ifdef MEALY_SCHED_STATS_EN
    ,
    .hit_cnt (hit_cnt)
`endif
  );

  mealy_rr_sched #(.NUM_CH(4), .RUN_LEN(3)) dut3 (
    .clock   (clock),
    .reset   (reset),
    .req     (req3),
    .w       (w3),
    .ch_clr  (clr3),
    .gnt     (gnt3),
    .z_valid (z_valid3),
    .z_ch    (z_ch3),
    .z       (z3)
`ifdef MEALY_SCHED_STATS_EN
    ,
    .hit_cnt (hit_cnt3)
`endif
  );

  // Advance one active edge and settle before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reset both DUTs; checks that outputs clear asynchronously.
  task automatic test_reset();
    logic [8:0] got;
    req = '0; w = '0; ch_clr = '0; req3 = '0; w3 = '0; clr3 = '0;
    reset = 1'b1;
    #1;
    got = {gnt, z_valid, z_ch, z, z_valid3};
    total++;
    if (got !== 9'b0) $display("FAIL reset_outputs: got %b expected %b", got, 9'b0);
    else passed++;
    step();
    reset = 1'b0;
  endtask

  task automatic test_single_channel();
    logic [3:0] wseq = 4'b1011;  // samples w0 = 1,1,0,1 after the leading 1
    logic [4:0] ws   = 5'b10111; // bit i = i-th sample: 1,1,1,0,1
    logic [4:0] zs   = 5'b00110; // bit i = expected z: 0,1,1,0,0
    logic [7:0] got, exp;
    wseq = wseq;
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      w = {3'b000, ws[i]};
      step();
      got = {gnt, z_valid, z_ch, z};
      exp = {4'b0001, 1'b1, 2'd0, zs[i]};
      total++;
      if (got !== exp) $display("FAIL single_ch cycle %0d: got %b expected %b", i, got, exp);
      else passed++;
    end
    req = '0;
  endtask

  task automatic test_all_channels();
    logic [7:0] got, exp;
    req = 4'b1111;
    w   = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      got = {gnt, z_valid, z_ch, z};
      exp = {4'b0001 << (i % 4), 1'b1, 2'(i % 4), (i >= 4)};
      total++;
      if (got !== exp) $display("FAIL all_ch cycle %0d: got %b expected %b", i, got, exp);
      else passed++;
    end
    req = '0; w = '0;
  endtask

  task automatic test_isolation();
    logic [7:0] got, exp;
    logic [1:0] ch;
    req = 4'b0110;
    w   = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      step();
      ch  = (i % 2 == 0) ? 2'd1 : 2'd2;
      exp = {4'b0001 << ch, 1'b1, ch, (ch == 2'd1) && (i >= 2)};
      got = {gnt, z_valid, z_ch, z};
      total++;
      if (got !== exp) $display("FAIL isolation cycle %0d: got %b expected %b", i, got, exp);
      else passed++;
    end
    req = '0; w = '0;
  endtask

  task automatic test_clear();
    logic [7:0] got, exp;
    req = 4'b0001; w = 4'b0001;
    step();
    got = {gnt, z_valid, z_ch, z};
    exp = {4'b0001, 1'b1, 2'd0, 1'b0};
    total++;
    if (got !== exp) $display("FAIL clear_first: got %b expected %b", got, exp);
    else passed++;
    ch_clr = 4'b0001;
    step();
    got = {gnt, z_valid, z_ch, z};
    exp = {4'b0000, 1'b0, 2'd0, 1'b0};
    total++;
    if (got !== exp) $display("FAIL clear_blocks_grant: got %b expected %b", got, exp);
    else passed++;
    ch_clr = '0;
    step();
    got = {gnt, z_valid, z_ch, z};
    exp = {4'b0001, 1'b1, 2'd0, 1'b0};
    total++;
    if (got !== exp) $display("FAIL clear_resets_run: got %b expected %b", got, exp);
    else passed++;
    req = '0; w = '0;
  endtask

  task automatic test_reset_midstream();
    logic [7:0] got, exp;
    w = 4'b1111;
    req = 4'b0010;
    step();  // grant ch1, ptr becomes 2
    req = 4'b1111;
    step();
    got = {gnt, z_valid, z_ch, z};
    exp = {4'b0100, 1'b1, 2'd2, 1'b0};
    total++;
    if (got !== exp) $display("FAIL mid_ptr2: got %b expected %b", got, exp);
    else passed++;
    reset = 1'b1;
    #1;
    got = {gnt, z_valid, z_ch, z};
    total++;
    if (got !== 8'b0) $display("FAIL mid_reset_async: got %b expected %b", got, 8'b0);
    else passed++;
    step();
    reset = 1'b0;
    step();
    got = {gnt, z_valid, z_ch, z};
    exp = {4'b0001, 1'b1, 2'd0, 1'b0};
    total++;
    if (got !== exp) $display("FAIL mid_restart_ch0: got %b expected %b", got, exp);
    else passed++;
    step();
    got = {gnt, z_valid, z_ch, z};
    exp = {4'b0010, 1'b1, 2'd1, 1'b0};  // ch1's earlier run was discarded
    total++;
    if (got !== exp) $display("FAIL mid_ch1_run_lost: got %b expected %b", got, exp);
    else passed++;
    req = '0; w = '0;
  endtask

  task automatic test_run_len3();
    logic [7:0] got, exp;
    logic [3:0] zs = 4'b1100;  // bit i = expected z: 0,0,1,1
    req3 = 4'b1000; w3 = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step();
      got = {gnt3, z_valid3, z_ch3, z3};
      exp = {4'b1000, 1'b1, 2'd3, zs[i]};
      total++;
      if (got !== exp) $display("FAIL runlen3 cycle %0d: got %b expected %b", i, got, exp);
      else passed++;
    end
`ifdef MEALY_SCHED_STATS_EN
    total++;
    if (hit_cnt3[63:48] !== 16'd2)
      $display("FAIL hit_cnt_ch3: got %0d expected %0d", hit_cnt3[63:48], 2);
    else passed++;
`endif
    req3 = '0; w3 = '0;
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_reset();
    test_all_channels();
    test_reset();
    test_isolation();
    test_reset();
    test_clear();
    test_reset();
    test_reset_midstream();
    test_reset();
    test_run_len3();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
